// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: instruction front-end for the 8-bit add / shift-left ALU.
// Decodes 16-bit words, drives the ALU, waits out its latency and writes the result back to a 4x8 register file.
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_imm,
  output logic        alu_opcode,
  input  logic [7:0]  alu_result,
  output logic        done_valid,
  output logic [7:0]  done_data,
  output logic        done_err,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  state_t      state_reg, state_next;
  logic        live_reg;
  logic [2:0]  cnt_reg;
  logic [1:0]  rd_reg;
  logic [7:0]  alu_a_reg, alu_b_reg;
  logic [2:0]  alu_imm_reg;
  logic        alu_opcode_reg;
  logic [7:0]  done_data_reg;
  logic        done_err_reg;
  logic [7:0]  rf_reg [4];

  logic [1:0]  op, rd, ra, rb;
  logic [7:0]  imm8;
  logic [2:0]  imm3;
  logic        accept, is_alu_op, exec_fire;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  wr_sel;

  assign op   = instr[15:14];
  assign rd   = instr[13:12];
  assign ra   = instr[11:10];
  assign rb   = instr[9:8];
  assign imm8 = instr[7:0];
  assign imm3 = instr[2:0];

  assign accept    = instr_valid & instr_ready;
  assign is_alu_op = (op == OP_SHL) || (op == OP_ADD);
  assign exec_fire = (state_reg == ST_EXEC) && (cnt_reg == 3'd0);

  // State register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = is_alu_op ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: begin
        if (cnt_reg == 3'd0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs; live_reg keeps ready low until the first edge after reset release
  always_comb begin
    instr_ready = (state_reg == ST_IDLE) && live_reg;
    done_valid  = (state_reg == ST_DONE);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      live_reg <= 1'b0;
    end else begin
      live_reg <= 1'b1;
    end
  end

  // Operand issue, latency counter and completion data
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_reg      <= 8'd0;
      alu_b_reg      <= 8'd0;
      alu_imm_reg    <= 3'd0;
      alu_opcode_reg <= 1'b0;
      cnt_reg        <= 3'd0;
      rd_reg         <= 2'd0;
      done_data_reg  <= 8'd0;
      done_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        rd_reg <= rd;
        case (op)
          OP_SHL: begin
            alu_a_reg      <= rf_reg[ra];
            alu_b_reg      <= 8'd0;
            alu_imm_reg    <= imm3;
            alu_opcode_reg <= 1'b0;
            cnt_reg        <= 3'(ALU_LATENCY);
          end
          OP_ADD: begin
            alu_a_reg      <= rf_reg[ra];
            alu_b_reg      <= rf_reg[rb];
            alu_imm_reg    <= 3'd0;
            alu_opcode_reg <= 1'b1;
            cnt_reg        <= 3'(ALU_LATENCY);
          end
          OP_LDI: begin
            done_data_reg <= imm8;
            done_err_reg  <= 1'b0;
          end
          default: begin
            done_data_reg <= 8'd0;
            done_err_reg  <= 1'b1;
          end
        endcase
      end else if (state_reg == ST_EXEC) begin
        if (cnt_reg != 3'd0) begin
          cnt_reg <= cnt_reg - 3'd1;
        end else begin
          done_data_reg <= alu_result;
          done_err_reg  <= 1'b0;
        end
      end
    end
  end

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_imm    = alu_imm_reg;
  assign alu_opcode = alu_opcode_reg;
  assign done_data  = done_data_reg;
  assign done_err   = done_err_reg;

  // Single write port: LDI writes at accept, ALU ops at the end of EXEC
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = imm8;
    if (accept && (op == OP_LDI)) begin
      wr_en = 1'b1;
    end else if (exec_fire) begin
      wr_en   = 1'b1;
      wr_addr = rd_reg;
      wr_data = alu_result;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wsel
      assign wr_sel[gi] = wr_en && (wr_addr == 2'(gi));
    end
  endgenerate

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rf_reg[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) begin
          rf_reg[i] <= wr_data;
        end
      end
    end
  end

  assign dbg_data = rf_reg[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one DUT with ALU_LATENCY=1, one with ALU_LATENCY=3,
// each paired with a behavioural registered ALU.
module tb_alu_issue_ctrl;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        rst_n;
  logic        valid;
  logic        use3;
  logic [15:0] instr;
  logic [1:0]  dbg_addr;

  logic       rdy1, opc1, dv1, de1;
  logic [7:0] a1, b1, res1, dd1, dbg1;
  logic [2:0] imm1;
  logic       rdy3, opc3, dv3, de3;
  logic [7:0] a3, b3, res3, dd3, dbg3;
  logic [2:0] imm3;

  alu_issue_ctrl #(.ALU_LATENCY(1)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .instr_valid(valid & ~use3), .instr_ready(rdy1),
    .instr(instr), .alu_a(a1), .alu_b(b1), .alu_imm(imm1), .alu_opcode(opc1),
    .alu_result(res1), .done_valid(dv1), .done_data(dd1), .done_err(de1),
    .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  alu_issue_ctrl #(.ALU_LATENCY(3)) dut3 (
    .sysclk(sysclk), .rst_n(rst_n), .instr_valid(valid & use3), .instr_ready(rdy3),
    .instr(instr), .alu_a(a3), .alu_b(b3), .alu_imm(imm3), .alu_opcode(opc3),
    .alu_result(res3), .done_valid(dv3), .done_data(dd3), .done_err(de3),
    .dbg_addr(dbg_addr), .dbg_data(dbg3)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] s, input logic o);
    return o ? 8'(a + b) : 8'(a << s);
  endfunction

  always @(posedge sysclk) res1 <= alu_f(a1, b1, imm1, opc1);

  logic [7:0] p3 [3];
  always @(posedge sysclk) begin
    p3[0] <= alu_f(a3, b3, imm3, opc3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign res3 = p3[2];

  // Views of whichever DUT is currently under test
  wire       rdy = use3 ? rdy3 : rdy1;
  wire       dv  = use3 ? dv3 : dv1;
  wire       de  = use3 ? de3 : de1;
  wire [7:0] dd  = use3 ? dd3 : dd1;
  wire [7:0] dbg = use3 ? dbg3 : dbg1;
  wire [7:0] ab  = use3 ? b3 : b1;
  wire [2:0] aim = use3 ? imm3 : imm1;
  wire       aop = use3 ? opc3 : opc1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    bit          u3;
    logic [7:0]  exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [1:0]  chk_addr;
    logic [7:0]  exp_reg;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input int i);
    vec_t v;
    int n, lat;
    logic [1:0] op;
    v = vecs[i];
    use3 = v.u3;
    dbg_addr = v.chk_addr;
    op = v.instr[15:14];
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge sysclk);
      n++;
    end
    chk($sformatf("v%0d ready", i), rdy, 1);
    instr = v.instr;
    valid = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    valid = 1'b0;
    lat = 1;
    if (op == 2'b00 || op == 2'b01) begin
      chk($sformatf("v%0d alu_opcode", i), aop, op[0]);
      chk($sformatf("v%0d alu_imm", i), aim, (op == 2'b01) ? 3'd0 : v.instr[2:0]);
      if (op == 2'b00) chk($sformatf("v%0d alu_b", i), ab, 0);
    end
    while (!dv && lat < 20) begin
      @(negedge sysclk);
      lat++;
    end
    chk($sformatf("v%0d latency", i), lat, v.exp_lat);
    chk($sformatf("v%0d done_data", i), dd, v.exp_data);
    chk($sformatf("v%0d done_err", i), de, v.exp_err);
    chk($sformatf("v%0d dbg r%0d", i, v.chk_addr), dbg, v.exp_reg);
    $display("vec %0d: instr=%04h lat=%0d data=%02h err=%0b", i, v.instr, lat, dd, de);
    @(negedge sysclk);
    chk($sformatf("v%0d pulse width", i), dv, 0);
  endtask

  logic [15:0] b2b_instr [3];
  logic [7:0]  b2b_exp   [3];

  initial begin
    int acc, nd, idx;
    bit acc_flag;

    vecs[0]  = '{16'h907F, 1'b0, 8'h7F, 1'b0, 1, 2'd1, 8'h7F};
    vecs[1]  = '{16'hA005, 1'b0, 8'h05, 1'b0, 1, 2'd2, 8'h05};
    vecs[2]  = '{16'h7600, 1'b0, 8'h84, 1'b0, 3, 2'd3, 8'h84};
    vecs[3]  = '{16'h80C8, 1'b0, 8'hC8, 1'b0, 1, 2'd0, 8'hC8};
    vecs[4]  = '{16'h4000, 1'b0, 8'h90, 1'b0, 3, 2'd0, 8'h90};
    vecs[5]  = '{16'h1003, 1'b0, 8'h80, 1'b0, 3, 2'd1, 8'h80};
    vecs[6]  = '{16'hE0FF, 1'b0, 8'h00, 1'b1, 1, 2'd2, 8'h05};
    vecs[7]  = '{16'h6900, 1'b0, 8'h85, 1'b0, 3, 2'd2, 8'h85};
    vecs[8]  = '{16'h3CF8, 1'b0, 8'h84, 1'b0, 3, 2'd3, 8'h84};
    vecs[9]  = '{16'h2B07, 1'b0, 8'h80, 1'b0, 3, 2'd2, 8'h80};
    vecs[10] = '{16'h907F, 1'b1, 8'h7F, 1'b0, 1, 2'd1, 8'h7F};
    vecs[11] = '{16'hA005, 1'b1, 8'h05, 1'b0, 1, 2'd2, 8'h05};
    vecs[12] = '{16'h7600, 1'b1, 8'h84, 1'b0, 5, 2'd3, 8'h84};
    vecs[13] = '{16'hE3FF, 1'b1, 8'h00, 1'b1, 1, 2'd3, 8'h84};
    b2b_instr[0] = 16'h8011; b2b_exp[0] = 8'h11;
    b2b_instr[1] = 16'h9022; b2b_exp[1] = 8'h22;
    b2b_instr[2] = 16'h6100; b2b_exp[2] = 8'h33;

    rst_n = 1'b0; valid = 1'b0; use3 = 1'b0; instr = 16'h0; dbg_addr = 2'd0;
    #2;
    chk("rst ready", rdy1, 0);
    chk("rst done_valid", dv1, 0);
    chk("rst done_data", dd1, 0);
    chk("rst done_err", de1, 0);
    chk("rst alu_a", a1, 0);
    chk("rst alu_opcode", opc1, 0);
    chk("rst dbg r0", dbg1, 0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    chk("post-rst ready", rdy1, 1);
    $display("reset released");

    for (int i = 0; i < 10; i++) run_vec(i);

    // Three instructions with instr_valid held high throughout
    use3 = 1'b0; acc = 0; nd = 0; idx = 0;
    instr = b2b_instr[0];
    valid = 1'b1;
    for (int c = 0; c < 40 && nd < 3; c++) begin
      if (dv) begin
        chk($sformatf("b2b done%0d data", nd), dd, b2b_exp[nd]);
        chk($sformatf("b2b done%0d ready", nd), rdy, 0);
        $display("b2b done %0d: data=%02h", nd, dd);
        nd++;
      end
      acc_flag = valid && rdy;
      if (acc_flag) acc++;
      @(negedge sysclk);
      if (acc_flag) begin
        idx++;
        if (idx < 3) instr = b2b_instr[idx];
        else valid = 1'b0;
      end
    end
    valid = 1'b0;
    chk("b2b accepts", acc, 3);
    chk("b2b dones", nd, 3);

    // Reset during EXEC of ADD r3=r2+r2
    dbg_addr = 2'd3;
    chk("pre-abort ready", rdy1, 1);
    instr = 16'h7A00;
    valid = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort ready", rdy1, 0);
    chk("abort alu_a", a1, 0);
    chk("abort alu_b", b1, 0);
    chk("abort alu_imm", imm1, 0);
    chk("abort alu_opcode", opc1, 0);
    chk("abort done_data", dd1, 0);
    chk("abort done_err", de1, 0);
    for (int k = 0; k < 4; k++) begin
      dbg_addr = 2'(k);
      #1;
      chk($sformatf("abort dbg r%0d", k), dbg1, 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge sysclk);
      chk("abort no done in rst", dv1, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge sysclk);
      chk("abort no done after rst", dv1, 0);
    end
    chk("abort ready after rst", rdy1, 1);
    dbg_addr = 2'd3;
    #1;
    chk("abort r3 cleared", dbg1, 0);
    $display("reset during EXEC: r3=%02h", dbg1);

    for (int i = 10; i < 14; i++) run_vec(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
